// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: peripheral requests, mask access and the CPU
// request/ack/return handshake. clk/rst stay outside as plain ports.
interface interrupt_controller_if #(
    parameter int NUM_SRC = 8,
    parameter int VEC_W   = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0] irq_in;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_din;
    logic [NUM_SRC-1:0] mask_out;
    logic               sei;
    logic               cli;
    logic               intr;
    logic [VEC_W-1:0]   intr_vec;
    logic               intr_ack;
    logic               reti;
    logic               in_service;
    logic [NUM_SRC-1:0] pending;
    logic               gie;

    modport master (
        output irq_in, mask_we, mask_din, sei, cli, intr_ack, reti,
        input  mask_out, intr, intr_vec, in_service, pending, gie
    );

    modport slave (
        input  irq_in, mask_we, mask_din, sei, cli, intr_ack, reti,
        output mask_out, intr, intr_vec, in_service, pending, gie
    );
endinterface

// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller for the RAT CPU: mask, GIE, lowest-index
// arbitration and the non-nesting ack/return handshake. Define INTC_EDGE_EN for edge-latched requests.
module interrupt_controller #(
    parameter int NUM_SRC = 8,
    parameter int VEC_W   = $clog2(NUM_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    interrupt_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] eligible;
    logic               gie;
    logic               intr;
    logic               in_service;
    logic [VEC_W-1:0]   intr_vec;
    logic [VEC_W-1:0]   first_vec;
    logic               ack_ok;
    logic               reti_ok;

    // Handshake pulses only count in the state that expects them.
    assign ack_ok   = bus.intr_ack && (state == REQ);
    assign reti_ok  = bus.reti && (state == SERVICE);
    assign eligible = pending & mask;

    always_comb begin
        first_vec = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) first_vec = VEC_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
        end else if (bus.mask_we) begin
            mask <= bus.mask_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gie <= 1'b0;
        end else if (ack_ok) begin
            gie <= 1'b0;
        end else if (reti_ok || bus.sei) begin
            gie <= 1'b1;
        end else if (bus.cli) begin
            gie <= 1'b0;
        end
    end

`ifdef INTC_EDGE_EN
    logic [NUM_SRC-1:0] irq_hist;
    logic [NUM_SRC-1:0] ack_clr;

    always_comb begin
        ack_clr = '0;
        if (ack_ok) ack_clr[intr_vec] = 1'b1;
    end

    // A fresh edge in the ack cycle is ORed in after the clear, so it survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_hist <= '0;
            pending  <= '0;
        end else begin
            irq_hist <= bus.irq_in;
            pending  <= (pending & ~ack_clr) | (bus.irq_in & ~irq_hist);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= bus.irq_in;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            intr       <= 1'b0;
            intr_vec   <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gie && (|eligible)) begin
                        intr_vec <= first_vec;
                        intr     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (ack_ok) begin
                        intr       <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SERVICE;
                    end else if (bus.cli) begin
                        intr  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (reti_ok) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    intr       <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.mask_out   = mask;
    assign bus.pending    = pending;
    assign bus.gie        = gie;
    assign bus.intr       = intr;
    assign bus.intr_vec   = intr_vec;
    assign bus.in_service = in_service;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: reset, arbitration, masking, CLI
// abort, stray handshake pulses and a re-arm of the same source during ack.
module tb_interrupt_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    interrupt_controller_if #(.NUM_SRC(8), .VEC_W(3)) bus ();

    interrupt_controller #(.NUM_SRC(8), .VEC_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulseAck();
        bus.intr_ack = 1'b1;
        applyStimulus(1);
        bus.intr_ack = 1'b0;
    endtask

    task automatic pulseReti();
        bus.reti = 1'b1;
        applyStimulus(1);
        bus.reti = 1'b0;
    endtask

    task automatic writeMask(input logic [7:0] value);
        bus.mask_we  = 1'b1;
        bus.mask_din = value;
        applyStimulus(1);
        bus.mask_we  = 1'b0;
    endtask

    initial begin
        bus.irq_in   = '0;
        bus.mask_we  = 1'b0;
        bus.mask_din = '0;
        bus.sei      = 1'b0;
        bus.cli      = 1'b0;
        bus.intr_ack = 1'b0;
        bus.reti     = 1'b0;
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(1);

        $display("[TB] reset state");
        checkOutput("rst_intr", 16'(bus.intr), 16'h0);
        checkOutput("rst_gie", 16'(bus.gie), 16'h0);
        checkOutput("rst_mask", 16'(bus.mask_out), 16'h00);
        checkOutput("rst_pending", 16'(bus.pending), 16'h00);
        checkOutput("rst_in_service", 16'(bus.in_service), 16'h0);
        checkOutput("rst_vec", 16'(bus.intr_vec), 16'h0);

        $display("[TB] reset while requesting");
        writeMask(8'hFF);
        bus.sei = 1'b1;
        applyStimulus(1);
        bus.sei = 1'b0;
        bus.irq_in = 8'h02;
        applyStimulus(2);
        checkOutput("t1_intr_before_rst", 16'(bus.intr), 16'h1);
        rst = 1'b1;
        #1;
        checkOutput("t1_intr_async", 16'(bus.intr), 16'h0);
        checkOutput("t1_gie_async", 16'(bus.gie), 16'h0);
        checkOutput("t1_mask_async", 16'(bus.mask_out), 16'h00);
        checkOutput("t1_pending_async", 16'(bus.pending), 16'h00);
        applyStimulus(1);
        bus.irq_in = '0;
        rst = 1'b0;
        applyStimulus(2);
        checkOutput("t1_idle_intr", 16'(bus.intr), 16'h0);
        checkOutput("t1_idle_in_service", 16'(bus.in_service), 16'h0);

        $display("[TB] single source 5");
        bus.mask_we  = 1'b1;
        bus.mask_din = 8'hFF;
        bus.sei      = 1'b1;
        applyStimulus(1);
        bus.mask_we  = 1'b0;
        bus.sei      = 1'b0;
        bus.irq_in   = 8'h20;
        applyStimulus(1);
        checkOutput("t2_pending", 16'(bus.pending), 16'h20);
        checkOutput("t2_intr_early", 16'(bus.intr), 16'h0);
        applyStimulus(1);
        checkOutput("t2_intr", 16'(bus.intr), 16'h1);
        checkOutput("t2_vec", 16'(bus.intr_vec), 16'h5);
        pulseAck();
        checkOutput("t2_ack_intr", 16'(bus.intr), 16'h0);
        checkOutput("t2_ack_in_service", 16'(bus.in_service), 16'h1);
        checkOutput("t2_ack_gie", 16'(bus.gie), 16'h0);
`ifdef INTC_EDGE_EN
        checkOutput("t2_ack_pending_cleared", 16'(bus.pending), 16'h00);
`else
        checkOutput("t2_ack_pending_level", 16'(bus.pending), 16'h20);
`endif
        bus.irq_in = '0;
        pulseReti();
        checkOutput("t2_reti_gie", 16'(bus.gie), 16'h1);
        checkOutput("t2_reti_in_service", 16'(bus.in_service), 16'h0);
        applyStimulus(1);
        checkOutput("t2_quiet", 16'(bus.intr), 16'h0);

        $display("[TB] stray ack in idle");
        pulseAck();
        checkOutput("stray_ack_gie", 16'(bus.gie), 16'h1);
        checkOutput("stray_ack_in_service", 16'(bus.in_service), 16'h0);

        $display("[TB] priority 3 over 5");
        bus.irq_in = 8'b0010_1000;
        applyStimulus(2);
        checkOutput("t3_intr", 16'(bus.intr), 16'h1);
        checkOutput("t3_vec", 16'(bus.intr_vec), 16'h3);
        pulseAck();
        bus.irq_in = 8'h20;
        applyStimulus(1);
        checkOutput("t3_pending", 16'(bus.pending), 16'h20);
        checkOutput("t3_vec_frozen", 16'(bus.intr_vec), 16'h3);
        pulseReti();
        applyStimulus(1);
        checkOutput("t3_second_intr", 16'(bus.intr), 16'h1);
        checkOutput("t3_second_vec", 16'(bus.intr_vec), 16'h5);
        pulseAck();
        bus.irq_in = '0;
        applyStimulus(1);
        pulseReti();
        applyStimulus(1);
        checkOutput("t3_quiet", 16'(bus.intr), 16'h0);

        $display("[TB] masked source");
        writeMask(8'h00);
        bus.irq_in = 8'h04;
        applyStimulus(1);
        checkOutput("t4_pending", 16'(bus.pending), 16'h04);
        applyStimulus(1);
        checkOutput("t4_masked_intr", 16'(bus.intr), 16'h0);
        writeMask(8'h04);
        checkOutput("t4_mask_out", 16'(bus.mask_out), 16'h04);
        applyStimulus(1);
        checkOutput("t4_unmasked_intr", 16'(bus.intr), 16'h1);
        checkOutput("t4_vec", 16'(bus.intr_vec), 16'h2);
        pulseAck();
        bus.irq_in = '0;
        applyStimulus(1);
        pulseReti();
        applyStimulus(1);

        $display("[TB] CLI abort");
        writeMask(8'hFF);
        bus.irq_in = 8'h02;
        applyStimulus(2);
        checkOutput("t5_intr", 16'(bus.intr), 16'h1);
        checkOutput("t5_vec", 16'(bus.intr_vec), 16'h1);
        bus.cli = 1'b1;
        applyStimulus(1);
        bus.cli = 1'b0;
        checkOutput("t5_cli_intr", 16'(bus.intr), 16'h0);
        checkOutput("t5_cli_gie", 16'(bus.gie), 16'h0);
        checkOutput("t5_cli_pending", 16'(bus.pending), 16'h02);
        pulseReti();
        checkOutput("stray_reti_gie", 16'(bus.gie), 16'h0);
        applyStimulus(1);
        checkOutput("t5_held_off", 16'(bus.intr), 16'h0);
        bus.sei = 1'b1;
        applyStimulus(1);
        bus.sei = 1'b0;
        applyStimulus(1);
        checkOutput("t5_sei_intr", 16'(bus.intr), 16'h1);
        checkOutput("t5_sei_vec", 16'(bus.intr_vec), 16'h1);
        pulseAck();
        bus.irq_in = '0;
        applyStimulus(1);
        pulseReti();
        applyStimulus(1);

        $display("[TB] SEI and CLI together");
        bus.cli = 1'b1;
        applyStimulus(1);
        checkOutput("cli_only_gie", 16'(bus.gie), 16'h0);
        bus.sei = 1'b1;
        applyStimulus(1);
        bus.sei = 1'b0;
        bus.cli = 1'b0;
        checkOutput("sei_cli_gie", 16'(bus.gie), 16'h1);

        $display("[TB] re-arm of source 4 during ack");
        bus.irq_in = 8'h10;
        applyStimulus(2);
        checkOutput("t6_intr", 16'(bus.intr), 16'h1);
        checkOutput("t6_vec", 16'(bus.intr_vec), 16'h4);
        bus.irq_in = 8'h00;
        applyStimulus(1);
        bus.irq_in = 8'h10;
        pulseAck();
        checkOutput("t6_pending_after_ack", 16'(bus.pending), 16'h10);
        checkOutput("t6_in_service", 16'(bus.in_service), 16'h1);
        pulseReti();
        applyStimulus(1);
        checkOutput("t6_refire_intr", 16'(bus.intr), 16'h1);
        checkOutput("t6_refire_vec", 16'(bus.intr_vec), 16'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
